request_capture: RTL

REQUEST_CAPTURE -- requirements
Module: request_capture

---
 rtl/request_pkg.sv | 19 +
 rtl/debounce_ch.sv | 47 ++++
 rtl/request_capture.sv | 65 ++++++
 3 files changed

// File: rtl/request_pkg.sv
// Shared constants and types for the request capture block.
package request_pkg;

  localparam int NCH_C = 4;
  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

  typedef logic [NCH_C-1:0] req_vec_t;

  function automatic logic [2:0] popcount4(input req_vec_t v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NCH_C; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One request channel: 2-flop synchronizer, stability counter, debounced level
// and a registered one-cycle pulse on each accepted 0->1 change.
module debounce_ch #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          rise_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        // Level held long enough: accept it; only a new high level is an event.
        stable_q <= sync2_q;
        cnt_q    <= '0;
        rise_q   <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/request_capture.sv
// Debounced request capture: latches rise events into a pending vector that the
// downstream encoder clears with ack, counting events lost to already-pending bits.
module request_capture
  import request_pkg::*;
#(
  parameter int DB_CYCLES = 500000,
  parameter int NCH       = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCH-1:0]    btn,
  input  logic              ack,
  input  logic [1:0]        ack_idx,
  output logic [NCH-1:0]    req,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int SW = DROP_W + 1;

  logic [NCH-1:0]    rise;
  logic [NCH-1:0]    ack_mask;
  logic [NCH-1:0]    drop_vec;
  logic [NCH-1:0]    req_q;
  logic [NCH-1:0]    req_d;
  logic [DROP_W-1:0] drop_q;
  logic [DROP_W-1:0] drop_d;
  logic [SW-1:0]     drop_sum;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    debounce_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .btn_i  (btn[gi]),
      .rise_o (rise[gi])
    );
  end

  always_comb begin
    ack_mask = '0;
    if (ack) begin
      ack_mask[ack_idx] = 1'b1;
    end
    // A rise coinciding with an ack on the same channel re-arms it instead of dropping.
    drop_vec = rise & req_q & ~ack_mask;
    req_d    = (req_q & ~ack_mask) | rise;
    drop_sum = {1'b0, drop_q} + SW'(popcount4(drop_vec));
    drop_d   = (drop_sum > {1'b0, DROP_MAX}) ? DROP_MAX : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q  <= '0;
      drop_q <= '0;
    end else begin
      req_q  <= req_d;
      drop_q <= drop_d;
    end
  end

  assign req      = req_q;
  assign drop_cnt = drop_q;

endmodule
